// File: rtl/ext_loader_pkg.sv
// Shared definitions for the external-memory loader: FSM state encoding and
// the phase-skipping helper used on every phase exit.
package ext_loader_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDump} ld_state_e;

    // First phase with non-zero length, or back to idle when none remain.
    function automatic ld_state_e skip_to(input logic load_nz, input logic run_nz,
                                          input logic dump_nz);
        if (load_nz) return StLoad;
        if (run_nz) return StRun;
        if (dump_nz) return StDump;
        return StIdle;
    endfunction

endpackage

// File: rtl/ext_rd_fifo.sv
// Two-entry read-data FIFO; absorbs the one-cycle DMEM read latency while the
// dump stream is back-pressured.
module ext_rd_fifo #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        count,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    always_comb begin
        rdata = mem_q[rd_ptr_q];
        count = count_q;
        empty = (count_q == 2'd0);
    end

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side initiator: writes a program into IMEM, runs the CPU for a fixed
// number of cycles, then streams a window of DMEM back out.
module ext_mem_loader
    import ext_loader_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned RUN_W     = 16,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [CNT_W-1:0]  load_len,
    input  logic [RUN_W-1:0]  run_cycles,
    input  logic [31:0]       dump_base,
    input  logic [CNT_W-1:0]  dump_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              cpu_enable,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic              busy,
    output logic              done
);

    ld_state_e         state_q;
    logic [CNT_W-1:0]  load_len_q, dump_len_q, idx_q, issue_cnt_q, pop_cnt_q;
    logic [RUN_W-1:0]  run_cycles_q, run_cnt_q;
    logic [31:0]       dump_base_q;
    logic              inflight_q, cpu_enable_q, done_q;

    logic [DATA_W-1:0] fifo_rdata;
    logic [1:0]        fifo_count, credit;
    logic              fifo_empty;
    logic              load_hs, last_load, last_run, issue, pop, last_pop, advance;
    ld_state_e         nxt;

    ext_rd_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .push  (inflight_q),
        .pop   (pop),
        .wdata (rdata_ext_2),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        s_ready   = (state_q == StLoad) && (idx_q < load_len_q);
        load_hs   = s_valid && s_ready;
        last_load = load_hs && (idx_q == load_len_q - CNT_W'(1));
        wen_ext   = load_hs;
        addr_ext  = load_hs ? 32'(idx_q) * 32'(ADDR_STEP) : '0;
        wdata_ext = load_hs ? s_data : '0;

        last_run  = (state_q == StRun) && (run_cnt_q == run_cycles_q - RUN_W'(1));

        m_valid   = !fifo_empty;
        m_data    = fifo_empty ? '0 : fifo_rdata;
        pop       = m_valid && m_ready;
        // A slot freed by this cycle's pop is reusable now, so 1 word/cycle sustains.
        credit     = fifo_count - 2'(pop) + 2'(inflight_q);
        issue      = (state_q == StDump) && (issue_cnt_q < dump_len_q) && (credit < 2'd2);
        ren_ext_2  = issue;
        addr_ext_2 = issue ? dump_base_q + 32'(issue_cnt_q) * 32'(ADDR_STEP) : '0;
        last_pop   = (state_q == StDump) && pop && (pop_cnt_q == dump_len_q - CNT_W'(1));

        ren_ext     = 1'b0;
        wen_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        busy        = (state_q != StIdle);
        cpu_enable  = cpu_enable_q;
        done        = done_q;

        advance = 1'b0;
        nxt     = StIdle;
        unique case (state_q)
            StIdle: begin
                advance = start;
                nxt     = skip_to(load_len != '0, run_cycles != '0, dump_len != '0);
            end
            StLoad: begin
                advance = last_load;
                nxt     = skip_to(1'b0, run_cycles_q != '0, dump_len_q != '0);
            end
            StRun: begin
                advance = last_run;
                nxt     = skip_to(1'b0, 1'b0, dump_len_q != '0);
            end
            StDump: begin
                advance = last_pop;
                nxt     = StIdle;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= StIdle;
            load_len_q   <= '0;
            run_cycles_q <= '0;
            dump_base_q  <= '0;
            dump_len_q   <= '0;
            idx_q        <= '0;
            run_cnt_q    <= '0;
            issue_cnt_q  <= '0;
            pop_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            cpu_enable_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (load_hs) idx_q <= idx_q + CNT_W'(1);
            if (state_q == StRun) run_cnt_q <= run_cnt_q + RUN_W'(1);
            if (issue) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            if (pop) pop_cnt_q <= pop_cnt_q + CNT_W'(1);
            if (state_q == StIdle && start) begin
                load_len_q   <= load_len;
                run_cycles_q <= run_cycles;
                dump_base_q  <= dump_base;
                dump_len_q   <= dump_len;
                idx_q        <= '0;
                run_cnt_q    <= '0;
                issue_cnt_q  <= '0;
                pop_cnt_q    <= '0;
            end
            if (advance) begin
                state_q      <= nxt;
                cpu_enable_q <= (nxt == StRun);
                done_q       <= (nxt == StIdle);
            end
        end
    end

endmodule

// File: tb/tb_ext_mem_loader.sv
// Scoreboard bench for ext_mem_loader: expected IMEM writes and dump words are
// queued at stimulus time and checked by a monitor process on the falling edge.
module tb_ext_mem_loader;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  load_len = '0;
    logic [15:0] run_cycles = '0;
    logic [31:0] dump_base = '0;
    logic [9:0]  dump_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        cpu_enable;
    logic [31:0] addr_ext, addr_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext, wdata_ext_2;
    logic [31:0] rdata_ext_2 = '0;
    logic        busy, done;

    ext_mem_loader dut (
        .clk(clk), .arst(arst), .start(start), .load_len(load_len), .run_cycles(run_cycles),
        .dump_base(dump_base), .dump_len(dump_len), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] wq[$];
    logic [31:0] dq[$];
    int cyc = 0, outst = 0;
    int wen_cnt = 0, wen_rise = 0, last_wen_cyc = 0;
    int en_cnt = 0, en_rise = 0, en_rise_cyc = 0;
    int mv_cnt = 0, mv_rise = 0, ren_cnt = 0, done_cnt = 0;
    bit prev_wen = 0, prev_en = 0, prev_mv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dmem(input logic [31:0] a);
        return 32'hD0 + ((a - 32'h100) >> 2);
    endfunction

    // DMEM model: data for an issued read is presented during the next cycle.
    task automatic dmem_model();
        logic        r;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            r = ren_ext_2;
            a = addr_ext_2;
            @(posedge clk);
            #1;
            if (r) rdata_ext_2 = dmem(a);
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        bit          pop;
        forever begin
            @(negedge clk);
            cyc++;
            if (arst) begin
                outst = 0; prev_wen = 0; prev_en = 0; prev_mv = 0;
                continue;
            end
            if (wen_ext) begin
                wen_cnt++;
                if (!prev_wen) wen_rise++;
                last_wen_cyc = cyc;
                if (wq.size() == 0) begin
                    check("wr_unexpected", wen_ext, 1'b0);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", addr_ext, e[63:32]);
                    check("wr_data", wdata_ext, e[31:0]);
                end
            end
            if (cpu_enable) begin
                en_cnt++;
                if (!prev_en) begin
                    en_rise++;
                    en_rise_cyc = cyc;
                end
            end
            pop = m_valid && m_ready;
            if (pop) begin
                mv_cnt++;
                if (dq.size() == 0) check("rd_unexpected", m_valid, 1'b0);
                else check("rd_data", m_data, dq.pop_front());
            end
            if (m_valid && !prev_mv) mv_rise++;
            if (ren_ext_2) begin
                ren_cnt++;
                check("rd_credit_ok", 32'((outst - int'(pop)) < 2), 32'd1);
            end
            outst = outst + int'(ren_ext_2) - int'(pop);
            if (done) done_cnt++;
            prev_wen = wen_ext; prev_en = cpu_enable; prev_mv = m_valid;
        end
    endtask

    task automatic do_start(input int ll, input int rc, input logic [31:0] db, input int dl);
        load_len = 10'(ll); run_cycles = 16'(rc); dump_base = db; dump_len = 10'(dl);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] d0, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = d0 + 32'(i);
            ok = 0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1;
                    break;
                end
            end
            check("load_ready", 32'(ok), 32'd1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic run_full(input logic [31:0] d0, input int run, input bit rnd);
        int w0 = wen_cnt, wr0 = wen_rise, e0 = en_cnt, er0 = en_rise;
        int p0 = mv_cnt, mr0 = mv_rise, r0 = ren_cnt, dn0 = done_cnt;
        bit got = 0;
        for (int k = 0; k < 4; k++) wq.push_back({32'(k * 4), d0 + 32'(k)});
        for (int k = 0; k < 6; k++) dq.push_back(32'hD0 + 32'(k));
        m_ready = 1'b1;
        do_start(4, run, 32'h100, 6);
        load_words(d0, 4);
        if (rnd) begin
            // start in RUN must be ignored
            do_start(7, 2, 32'h0, 1);
            load_len = '0; run_cycles = '0; dump_len = '0;
        end
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                break;
            end
            if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
        check("done_seen", 32'(got), 32'd1);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("wen_count", 32'(wen_cnt - w0), 32'd4);
        check("wen_one_burst", 32'(wen_rise - wr0), 32'd1);
        check("en_cycles", 32'(en_cnt - e0), 32'(run));
        check("en_one_pulse", 32'(en_rise - er0), 32'd1);
        check("en_start_cyc", 32'(en_rise_cyc), 32'(last_wen_cyc + 1));
        check("dump_words", 32'(mv_cnt - p0), 32'd6);
        check("ren_count", 32'(ren_cnt - r0), 32'd6);
        if (!rnd) check("dump_one_burst", 32'(mv_rise - mr0), 32'd1);
        check("done_once", 32'(done_cnt - dn0), 32'd1);
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("dq_empty", 32'(dq.size()), 32'd0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int w0, e0, r0, dn0;
        fork
            monitor();
            dmem_model();
        join_none

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_cpu_en", cpu_enable, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_wen", wen_ext, 1'b0);
        check("rst_ren2", ren_ext_2, 1'b0);
        check("rst_addr2", addr_ext_2, 32'h0);
        check("rst_m_data", m_data, 32'h0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        @(posedge clk);
        #1;

        run_full(32'hA0, 5, 1'b0);
        run_full(32'hA0, 5, 1'b1);

        // all phases empty: straight through with only a done pulse
        w0 = wen_cnt; e0 = en_cnt; r0 = ren_cnt; dn0 = done_cnt;
        do_start(0, 0, 32'h100, 0);
        check("zero_done_next", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("zero_wen", 32'(wen_cnt - w0), 32'd0);
        check("zero_en", 32'(en_cnt - e0), 32'd0);
        check("zero_ren", 32'(ren_cnt - r0), 32'd0);
        check("zero_done_once", 32'(done_cnt - dn0), 32'd1);

        // asynchronous abort on the second RUN cycle
        wq.push_back({32'h0, 32'hB0});
        wq.push_back({32'h4, 32'hB1});
        do_start(2, 8, 32'h100, 2);
        load_words(32'hB0, 2);
        check("abort_en_pre", cpu_enable, 1'b1);
        @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        check("abort_en", cpu_enable, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ren2", ren_ext_2, 1'b0);
        check("abort_m_valid", m_valid, 1'b0);
        check("abort_wq_empty", 32'(wq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        dq.delete();
        @(posedge clk);
        #1;

        run_full(32'hC0, 5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
